// File: rtl/dense_ctrl.sv
// dense_ctrl -- sequencing controller for the dense (fully-connected) layer.
//
// Steps the dense MAC datapath through OUT_LEN output neurons. Each neuron
// gets IN_LEN products accumulated. The controller generates loop indices,
// the memory read strobe, the MAC clear/enable strobes and the result-write
// handshake. Every output is decoded from registered state, so no input
// reaches an output combinationally.
//
// Per neuron: CLR (1) -> RUN (IN_LEN) -> DRAIN (MAC_LAT) -> WRITE (>=1),
// and one DONE cycle after the last neuron.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   start      begin layer computation; only looked at in IDLE
//   in_idx     input-neuron index (input buffer / weight column address)
//   out_idx    output-neuron index (weight row / bias / result address)
//   rd_en      read strobe for input/weight memories (1-cycle read latency)
//   mac_clr    load accumulator with bias / zero
//   mac_en     accumulate current product (rd_en delayed one cycle)
//   res_valid  accumulator result valid for out_idx
//   res_ready  result sink accepts; transfer on res_valid & res_ready
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last result transfer
module dense_ctrl #(
  parameter int IN_LEN  = 64,
  parameter int OUT_LEN = 10,
  parameter int IN_W    = 6,
  parameter int OUT_W   = 4,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  in_idx,
  output logic [OUT_W-1:0] out_idx,
  output logic             rd_en,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             done
);

  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_LEN - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_LEN - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  in_idx_q, in_idx_d;
  logic [OUT_W-1:0] out_idx_q, out_idx_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             mac_en_p1;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      drn_q     <= '0;
      mac_en_p1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      drn_q     <= drn_d;
      // MAC stage sees the operand one cycle after the read strobe
      mac_en_p1 <= (state_q == RUN);
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    drn_d     = drn_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = CLR;
      end
      CLR: begin
        in_idx_d = '0;
        drn_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        if (in_idx_q == IN_LAST) begin
          in_idx_d = '0;
          drn_d    = '0;
          state_d  = DRAIN;
        end else begin
          in_idx_d = in_idx_q + 1'b1;
        end
      end
      DRAIN: begin
        // Wait out the MAC pipeline so the accumulator holds the final sum
        if (drn_q == DRN_LAST) begin
          drn_d   = '0;
          state_d = WRITE;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      WRITE: begin
        if (res_ready) begin
          if (out_idx_q == OUT_LAST) begin
            out_idx_d = '0;
            state_d   = DONE;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
            state_d   = CLR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_idx    = in_idx_q;
  assign out_idx   = out_idx_q;
  assign rd_en     = (state_q == RUN);
  assign mac_clr   = (state_q == CLR);
  assign mac_en    = mac_en_p1;
  assign res_valid = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
